// File: rtl/config_loader.sv
// Configuration chain loader.
// Accepts WORD_W-bit words over a valid/ready handshake and shifts them
// LSB-first into a serial configuration chain of CHAIN_LEN bits. Once the
// full chain is loaded the fabric run enable (clb_en) is raised. The loader
// gives up with an error when it is aborted or starved for TIMEOUT cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | out of reset, waiting for start
// LOAD  | accepting words and shifting bits into the chain
// DONE  | chain fully loaded, fabric enabled, outputs held
// ERROR | pass ended by abort or starve timeout, fabric disabled
module config_loader #(
    parameter int CHAIN_LEN = 552,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 255,
    localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              prog_in,
    output logic              prog_en,
    output logic              clb_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int REM_W = $clog2(WORD_W + 1);
    localparam int ST_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              prog_en_q, prog_en_d;
    logic              prog_in_q, prog_in_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              clb_en_q, clb_en_d;

    logic [CNT_W-1:0]  bc_next;
    logic              chain_full;
    logic              ready_c;
    logic              xfer;
    logic              starved;

    // Handshake and status terms derived from the current register state.
    // rem_q counts the word bits still waiting behind the one on prog_in, so
    // rem_q == 0 covers both "empty" and "presenting the final bit".
    always_comb begin
        bc_next    = bit_count_q + CNT_W'(prog_en_q);
        chain_full = (bc_next == CNT_W'(CHAIN_LEN));
        ready_c    = (state_q == ST_LOAD) && (rem_q == '0) && !chain_full;
        xfer       = cfg_valid && ready_c;
        starved    = (rem_q == '0) && !prog_en_q && !xfer;
    end

    // Next-state and datapath update; abort beats completion beats timeout.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        rem_d       = rem_q;
        prog_en_d   = 1'b0;
        prog_in_d   = prog_in_q;
        bit_count_d = bit_count_q;
        starve_d    = starve_q;
        done_d      = done_q;
        error_d     = error_q;
        clb_en_d    = clb_en_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    bit_count_d = '0;
                    starve_d    = '0;
                    rem_d       = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    clb_en_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                bit_count_d = bc_next;
                if (xfer) begin
                    prog_en_d = 1'b1;
                    prog_in_d = cfg_data[0];
                    sr_d      = cfg_data >> 1;
                    rem_d     = REM_W'(WORD_W - 1);
                end else if (rem_q != '0) begin
                    prog_en_d = 1'b1;
                    prog_in_d = sr_q[0];
                    sr_d      = sr_q >> 1;
                    rem_d     = rem_q - REM_W'(1);
                end
                starve_d = starved ? starve_q + ST_W'(1) : '0;

                if (abort) begin
                    state_d   = ST_ERROR;
                    error_d   = 1'b1;
                    prog_en_d = 1'b0;
                    prog_in_d = prog_in_q;
                    rem_d     = '0;
                    starve_d  = '0;
                end else if (chain_full) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    clb_en_d  = 1'b1;
                    prog_en_d = 1'b0;
                    prog_in_d = prog_in_q;
                    rem_d     = '0;
                    starve_d  = '0;
                end else if (starved && (starve_q == ST_W'(TIMEOUT - 1))) begin
                    state_d  = ST_ERROR;
                    error_d  = 1'b1;
                    rem_d    = '0;
                    starve_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge prog_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            rem_q       <= '0;
            prog_en_q   <= 1'b0;
            prog_in_q   <= 1'b0;
            bit_count_q <= '0;
            starve_q    <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clb_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            rem_q       <= rem_d;
            prog_en_q   <= prog_en_d;
            prog_in_q   <= prog_in_d;
            bit_count_q <= bit_count_d;
            starve_q    <= starve_d;
            done_q      <= done_d;
            error_q     <= error_d;
            clb_en_q    <= clb_en_d;
        end
    end

    assign cfg_ready = ready_c;
    assign prog_in   = prog_in_q;
    assign prog_en   = prog_en_q;
    assign busy      = (state_q == ST_LOAD);
    assign done      = done_q;
    assign error     = error_q;
    assign clb_en    = clb_en_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a control-state vector table followed by
// hand-written multi-cycle stream scenarios.
module tb_config_loader;

    localparam int CHAIN_LEN = 552;
    localparam int WORD_W    = 8;
    localparam int TIMEOUT   = 255;
    localparam int NWORDS    = CHAIN_LEN / WORD_W;
    localparam int CNT_W     = 10;

    logic             prog_clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WORD_W-1:0] cfg_data;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             prog_in;
    logic             prog_en;
    logic             clb_en;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] bit_count;

    int n_checks = 0;
    int n_errors = 0;

    // per-stream observations
    int s_n_en, s_first_en, s_last_en, s_order_err, s_hold_err;
    int s_end_cyc, s_first_hs, s_ended;

    config_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .prog_clk (prog_clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .prog_in  (prog_in),
        .prog_en  (prog_en),
        .clb_en   (clb_en),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .bit_count(bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish, required finish before 1000000");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // 69-bit row image, repeated over the chain
    function automatic logic img_bit(input int k);
        int r;
        r = k % 69;
        return ((((r * 5) + 3) % 7) < 3) ^ ((r % 4) == 1);
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input int idx);
        logic [WORD_W-1:0] w;
        w = '0;
        if (idx < NWORDS)
            for (int j = 0; j < WORD_W; j++) w[j] = img_bit(idx * WORD_W + j);
        return w;
    endfunction

    // Start a pass from IDLE/DONE/ERROR and check the entry into LOAD.
    task automatic do_start(input string tag);
        @(negedge prog_clk);
        start     = 1'b1;
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1;
        chk({tag, "_start_busy"}, 32'(busy), 1);
        chk({tag, "_start_clear"}, {26'd0, done, error, clb_en, 3'd0} | 32'(bit_count), 0);
        start = 1'b0;
    endtask

    // Feed up to nwords words; after each accepted word hold cfg_valid low
    // for 'gap' cycles. Returns early when en count hits stop_at (>0).
    task automatic run_stream(input int nwords, input int gap, input int stop_at, input int max_cyc);
        int cyc, idx, gap_cnt;
        logic hs_prev, last_pin;
        cyc = 0; idx = 0; gap_cnt = 0; hs_prev = 1'b0; last_pin = 1'b0;
        s_n_en = 0; s_first_en = -1; s_last_en = -1; s_order_err = 0;
        s_hold_err = 0; s_end_cyc = -1; s_first_hs = -1; s_ended = 0;
        while (cyc < max_cyc) begin
            @(negedge prog_clk);
            cyc++;
            if (prog_en) begin
                if (s_n_en >= CHAIN_LEN || prog_in !== img_bit(s_n_en)) s_order_err++;
                if (s_n_en == 0) s_first_en = cyc;
                s_last_en = cyc;
                s_n_en++;
                last_pin = prog_in;
            end else if (s_n_en > 0 && prog_in !== last_pin) begin
                s_hold_err++;
            end
            if (done || error) begin
                s_end_cyc = cyc;
                s_ended   = 1;
                break;
            end
            if (stop_at > 0 && s_n_en == stop_at) begin
                s_ended = 1;
                break;
            end
            if (hs_prev) begin
                idx++;
                gap_cnt = gap;
            end
            if (gap_cnt > 0) begin
                cfg_valid = 1'b0;
                gap_cnt--;
            end else begin
                cfg_valid = (idx < nwords);
            end
            cfg_data = word_of(idx);
            hs_prev  = cfg_valid && cfg_ready;
            if (hs_prev && s_first_hs < 0) s_first_hs = cyc;
        end
        if (!s_ended) begin
            n_checks++;
            n_errors++;
            $display("FAIL stream_bound: no end after %0d cycles, required done/error/stop", max_cyc);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic check_full_pass(input string tag);
        chk({tag, "_en_count"}, s_n_en, CHAIN_LEN);
        chk({tag, "_bit_order_errs"}, s_order_err, 0);
        chk({tag, "_done_flags"}, {29'd0, done, clb_en, error}, 32'b110);
        chk({tag, "_prog_en_after"}, 32'(prog_en), 0);
        chk({tag, "_bit_count"}, 32'(bit_count), CHAIN_LEN);
        chk({tag, "_done_latency"}, s_end_cyc - s_last_en, 1);
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic       valid;
        logic [6:0] exp;     // {busy, cfg_ready, done, error, clb_en, prog_en, prog_in}
        int         exp_bc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cnt;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 7'b0000000, 0}; // IDLE: abort and words ignored
        vecs[1] = '{1'b1, 1'b1, 1'b0, 7'b1100000, 0}; // start wins over abort
        vecs[2] = '{1'b0, 1'b0, 1'b1, 7'b1000011, 0}; // word 0xA5 taken, bit0=1
        vecs[3] = '{1'b0, 1'b0, 1'b0, 7'b1000010, 1}; // bit1=0
        vecs[4] = '{1'b0, 1'b1, 1'b0, 7'b0001000, 2}; // abort -> ERROR
        vecs[5] = '{1'b0, 1'b1, 1'b1, 7'b0001000, 2}; // ERROR holds
        vecs[6] = '{1'b1, 1'b0, 1'b0, 7'b1100000, 0}; // restart clears error
        vecs[7] = '{1'b0, 1'b1, 1'b1, 7'b0001000, 0}; // abort beats transfer

        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'hA5;
        repeat (3) @(posedge prog_clk);
        #1;
        chk("reset_outputs", {24'd0, busy, cfg_ready, done, error, clb_en, prog_en, prog_in, 1'b0} | 32'(bit_count), 0);
        @(negedge prog_clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge prog_clk);
            start = vecs[i].start; abort = vecs[i].abort; cfg_valid = vecs[i].valid; cfg_data = 8'hA5;
            @(posedge prog_clk);
            #1;
            chk($sformatf("vec%0d_outputs", i), {25'd0, busy, cfg_ready, done, error, clb_en, prog_en, prog_in}, {25'd0, vecs[i].exp});
            chk($sformatf("vec%0d_bit_count", i), 32'(bit_count), vecs[i].exp_bc);
        end
        @(negedge prog_clk);
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;

        // continuous stream
        do_start("cont");
        run_stream(NWORDS, 0, 0, 2000);
        check_full_pass("cont");
        chk("cont_consecutive", s_last_en - s_first_en + 1, CHAIN_LEN);
        chk("cont_first_latency", s_first_en - s_first_hs, 1);

        // abort in DONE is ignored
        @(negedge prog_clk);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("done_abort_ignored", {29'd0, done, clb_en, busy}, 32'b110);

        // reprogram from DONE with 1,0,0 gapped stream
        do_start("reprog");
        run_stream(NWORDS, 2, 0, 2000);
        check_full_pass("gap2");

        // longer gaps: starve cycles with prog_in held
        do_start("gap12");
        run_stream(NWORDS, 12, 0, 3000);
        check_full_pass("gap12");
        chk("gap12_hold_errs", s_hold_err, 0);

        // timeout after 10 words
        do_start("tmo");
        run_stream(10, 0, 0, 600);
        chk("tmo_flags", {29'd0, error, done, clb_en}, 32'b100);
        chk("tmo_bit_count", 32'(bit_count), 80);
        chk("tmo_en_count", s_n_en, 80);
        chk("tmo_latency", s_end_cyc - s_last_en, TIMEOUT + 1);
        chk("tmo_hold_errs", s_hold_err, 0);

        // abort at bit 300
        do_start("abort");
        run_stream(NWORDS, 0, 300, 2000);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("abort_flags", {28'd0, error, busy, cfg_ready, prog_en}, 32'b1000);
        chk("abort_bc_range", 32'((bit_count == 10'd300) || (bit_count == 10'd301)), 1);
        chk("abort_order_errs", s_order_err, 0);
        cnt = 0;
        cfg_valid = 1'b1;
        repeat (20) begin
            @(negedge prog_clk);
            if (prog_en) cnt++;
        end
        cfg_valid = 1'b0;
        chk("abort_no_prog_en", cnt, 0);
        chk("abort_error_held", {30'd0, error, clb_en}, 32'b10);

        // reset mid-pass, then a full pass
        do_start("rstmid");
        run_stream(NWORDS, 0, 200, 2000);
        rst = 1'b1;
        @(negedge prog_clk);
        rst = 1'b0;
        cfg_valid = 1'b0;
        chk("rstmid_outputs", {24'd0, busy, cfg_ready, done, error, clb_en, prog_en, prog_in, 1'b0} | 32'(bit_count), 0);
        cnt = 0;
        repeat (10) begin
            @(negedge prog_clk);
            if (prog_en || busy) cnt++;
        end
        chk("rstmid_quiet", cnt, 0);
        do_start("after_rst");
        run_stream(NWORDS, 0, 0, 2000);
        check_full_pass("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
